// File: rtl/csm_pkg.sv
// -----------------------------------------------------------------------------
// csm_pkg
// Shared types for the CSM shared-register memory: the operation encoding,
// the lock ownership encoding (also the lock_owner output value) and the
// port identifiers used by the round-robin arbiter.
// -----------------------------------------------------------------------------
package csm_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_READ    = 3'd1,
        OP_WRITE   = 3'd2,
        OP_HOLD    = 3'd3,
        OP_RELEASE = 3'd4
    } csm_op_t;

    typedef enum logic [1:0] {
        LK_FREE = 2'b00,
        LK_A    = 2'b01,
        LK_B    = 2'b10
    } lock_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Lock encoding a given port would hold if it owned the lock.
    function automatic lock_t lock_of(input logic port);
        return (port == PORT_B) ? LK_B : LK_A;
    endfunction

endpackage

// File: rtl/csm_shared_mem_if.sv
// -----------------------------------------------------------------------------
// csm_shared_mem_if
// One processor port of the shared memory.
//   req/op/addr/wdata : request, held stable by the master until gnt
//   gnt               : operation accepted this cycle (combinational)
//   done/rdata/err    : registered completion, one cycle after acceptance
// Modports: master (processor side), slave (memory side).
// -----------------------------------------------------------------------------
interface csm_shared_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) ();
    import csm_pkg::*;

    logic              req;
    csm_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, op, addr, wdata,
        input  gnt, done, rdata, err
    );

    modport slave (
        input  req, op, addr, wdata,
        output gnt, done, rdata, err
    );

endinterface

// File: rtl/csm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// csm_rr_arbiter
// Two-requester round-robin arbiter with a combinational one-hot grant.
//   clk, reset_n   : clock, async active-low reset
//   req_a, req_b   : requests from port A / port B
//   gnt_a, gnt_b   : one-hot grant, forced low while reset_n is low
// rr_last remembers the last port served; on a tie the other port wins.
// It resets to PORT_B so that A wins the first tie.
// -----------------------------------------------------------------------------
module csm_rr_arbiter
    import csm_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic rr_last;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (reset_n) begin
            if (req_a && (!req_b || rr_last == PORT_B)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= PORT_B;
        end else if (gnt_a) begin
            rr_last <= PORT_A;
        end else if (gnt_b) begin
            rr_last <= PORT_B;
        end
    end

endmodule

// File: rtl/csm_shared_mem.sv
// -----------------------------------------------------------------------------
// csm_shared_mem
// Dual-port DEPTH x DATA_W shared register memory with one exclusive lock.
//   clk, reset_n   : clock, async active-low reset
//   port_a, port_b : processor ports (req/gnt handshake, registered response)
//   lock_owner     : 00 free, 01 held by A, 10 held by B
// At most one operation is accepted per cycle. A held lock is force-released
// after HOLD_TIMEOUT cycles without an accepted op from its owner (0 = never).
//
// Lock FSM
//   state   | meaning
//   --------+-------------------------------------------------------
//   LK_FREE | nobody holds the lock, both ports may access memory
//   LK_A    | port A holds the lock, only A may access memory
//   LK_B    | port B holds the lock, only B may access memory
// -----------------------------------------------------------------------------
module csm_shared_mem
    import csm_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 2,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    csm_shared_mem_if.slave        port_a,
    csm_shared_mem_if.slave        port_b,
    output logic [1:0]             lock_owner
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_W   = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam int TO_LAST = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;
    localparam bit TO_EN   = (HOLD_TIMEOUT > 0);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              gnt_a;
    logic              gnt_b;
    logic              accept;
    logic              sel_port;
    csm_op_t           sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    lock_t             lock_q;
    lock_t             lock_d;
    lock_t             req_lock;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              is_owner;
    logic              may_access;

    logic              op_err;
    logic              do_write;
    logic [DATA_W-1:0] rd_val;

    logic              done_a;
    logic              err_a;
    logic [DATA_W-1:0] rdata_a;
    logic              done_b;
    logic              err_b;
    logic [DATA_W-1:0] rdata_b;

    csm_rr_arbiter u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_a   (port_a.req),
        .req_b   (port_b.req),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    assign port_a.gnt = gnt_a;
    assign port_b.gnt = gnt_b;

    // Only one port can be granted, so a single datapath serves both.
    assign accept    = gnt_a | gnt_b;
    assign sel_port  = gnt_b ? PORT_B : PORT_A;
    assign sel_op    = gnt_b ? port_b.op    : port_a.op;
    assign sel_addr  = gnt_b ? port_b.addr  : port_a.addr;
    assign sel_wdata = gnt_b ? port_b.wdata : port_a.wdata;

    assign req_lock   = lock_of(sel_port);
    assign is_owner   = (lock_q == req_lock);
    assign may_access = (lock_q == LK_FREE) || is_owner;

    always_comb begin
        op_err   = 1'b0;
        do_write = 1'b0;
        rd_val   = '0;
        case (sel_op)
            OP_NOP: begin
                op_err = 1'b0;
            end
            OP_READ: begin
                op_err = !may_access;
                if (may_access) begin
                    rd_val = mem[sel_addr];
                end
            end
            OP_WRITE: begin
                op_err   = !may_access;
                do_write = may_access;
            end
            OP_HOLD: begin
                // Re-holding an already owned lock is harmless.
                op_err = !may_access;
            end
            OP_RELEASE: begin
                op_err = !is_owner;
            end
            default: begin
                // Unassigned opcodes complete but flag an error.
                op_err = 1'b1;
            end
        endcase
    end

    // Lock FSM next state and hold-timeout counter. An accepted op from the
    // owner always takes priority over an expiring timeout.
    always_comb begin
        lock_d = lock_q;
        cnt_d  = cnt_q;
        if (TO_EN && lock_q != LK_FREE) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept && is_owner) begin
            cnt_d = '0;
            if (sel_op == OP_RELEASE) begin
                lock_d = LK_FREE;
            end
        end else if (accept && sel_op == OP_HOLD && lock_q == LK_FREE) begin
            lock_d = req_lock;
            cnt_d  = '0;
        end else if (TO_EN && lock_q != LK_FREE && cnt_q == CNT_W'(TO_LAST)) begin
            lock_d = LK_FREE;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= LK_FREE;
            cnt_q  <= '0;
        end else begin
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && do_write) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_a  <= 1'b0;
            err_a   <= 1'b0;
            rdata_a <= '0;
            done_b  <= 1'b0;
            err_b   <= 1'b0;
            rdata_b <= '0;
        end else begin
            done_a  <= gnt_a;
            err_a   <= gnt_a & op_err;
            rdata_a <= gnt_a ? rd_val : '0;
            done_b  <= gnt_b;
            err_b   <= gnt_b & op_err;
            rdata_b <= gnt_b ? rd_val : '0;
        end
    end

    assign port_a.done  = done_a;
    assign port_a.err   = err_a;
    assign port_a.rdata = rdata_a;
    assign port_b.done  = done_b;
    assign port_b.err   = err_b;
    assign port_b.rdata = rdata_b;

    assign lock_owner = lock_q;

endmodule

// File: tb/tb_csm_shared_mem.sv
// -----------------------------------------------------------------------------
// tb_csm_shared_mem
// Directed, table-driven bench. Instance 0 uses the default hold timeout,
// instance 1 uses HOLD_TIMEOUT = 4. Each table row is one clock cycle:
// inputs for both ports, expected grants in that cycle and expected
// responses and lock owner after the clock edge.
// -----------------------------------------------------------------------------
module tb_csm_shared_mem;
    import csm_pkg::*;

    typedef struct {
        logic       a_req;
        csm_op_t    a_op;
        logic [1:0] a_addr;
        logic [7:0] a_wd;
        logic       b_req;
        csm_op_t    b_op;
        logic [1:0] b_addr;
        logic [7:0] b_wd;
        logic       e_ag;
        logic       e_bg;
        logic       e_ad;
        logic       e_ae;
        logic [7:0] e_ard;
        logic       e_bd;
        logic       e_be;
        logic [7:0] e_brd;
        logic [1:0] e_lock;
    } vec_t;

    logic clk;
    logic rst_n;

    logic       req   [2][2];
    csm_op_t    op    [2][2];
    logic [1:0] addr  [2][2];
    logic [7:0] wd    [2][2];
    logic       gnt   [2][2];
    logic       done  [2][2];
    logic [7:0] rdata [2][2];
    logic       err   [2][2];
    logic [1:0] owner [2];

    int n_vec;
    int n_err;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        csm_shared_mem_if #(.DATA_W(8), .ADDR_W(2)) ifa ();
        csm_shared_mem_if #(.DATA_W(8), .ADDR_W(2)) ifb ();

        assign ifa.req   = req[d][0];
        assign ifa.op    = op[d][0];
        assign ifa.addr  = addr[d][0];
        assign ifa.wdata = wd[d][0];
        assign ifb.req   = req[d][1];
        assign ifb.op    = op[d][1];
        assign ifb.addr  = addr[d][1];
        assign ifb.wdata = wd[d][1];

        assign gnt[d][0]   = ifa.gnt;
        assign done[d][0]  = ifa.done;
        assign rdata[d][0] = ifa.rdata;
        assign err[d][0]   = ifa.err;
        assign gnt[d][1]   = ifb.gnt;
        assign done[d][1]  = ifb.done;
        assign rdata[d][1] = ifb.rdata;
        assign err[d][1]   = ifb.err;

        csm_shared_mem #(
            .DATA_W       (8),
            .ADDR_W       (2),
            .HOLD_TIMEOUT ((d == 0) ? 64 : 4)
        ) u_dut (
            .clk        (clk),
            .reset_n    (rst_n),
            .port_a     (ifa.slave),
            .port_b     (ifb.slave),
            .lock_owner (owner[d])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(
        input logic a_req, input csm_op_t a_op, input logic [1:0] a_addr, input logic [7:0] a_wd,
        input logic b_req, input csm_op_t b_op, input logic [1:0] b_addr, input logic [7:0] b_wd,
        input logic e_ag, input logic e_bg,
        input logic e_ad, input logic e_ae, input logic [7:0] e_ard,
        input logic e_bd, input logic e_be, input logic [7:0] e_brd,
        input logic [1:0] e_lock);
        vec_t t;
        t.a_req = a_req; t.a_op = a_op; t.a_addr = a_addr; t.a_wd = a_wd;
        t.b_req = b_req; t.b_op = b_op; t.b_addr = b_addr; t.b_wd = b_wd;
        t.e_ag = e_ag; t.e_bg = e_bg;
        t.e_ad = e_ad; t.e_ae = e_ae; t.e_ard = e_ard;
        t.e_bd = e_bd; t.e_be = e_be; t.e_brd = e_brd;
        t.e_lock = e_lock;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p]  = 1'b0;
                op[d][p]   = OP_NOP;
                addr[d][p] = 2'd0;
                wd[d][p]   = 8'h00;
            end
        end
    endtask

    task automatic run(input int d, input vec_t t, input string tag, input int idx);
        @(negedge clk);
        req[d][0] = t.a_req; op[d][0] = t.a_op; addr[d][0] = t.a_addr; wd[d][0] = t.a_wd;
        req[d][1] = t.b_req; op[d][1] = t.b_op; addr[d][1] = t.b_addr; wd[d][1] = t.b_wd;
        #1;
        chk({tag, " a_gnt"}, idx, {7'd0, gnt[d][0]}, {7'd0, t.e_ag});
        chk({tag, " b_gnt"}, idx, {7'd0, gnt[d][1]}, {7'd0, t.e_bg});
        @(posedge clk);
        #1;
        chk({tag, " a_done"},  idx, {7'd0, done[d][0]}, {7'd0, t.e_ad});
        chk({tag, " a_err"},   idx, {7'd0, err[d][0]},  {7'd0, t.e_ae});
        chk({tag, " a_rdata"}, idx, rdata[d][0], t.e_ard);
        chk({tag, " b_done"},  idx, {7'd0, done[d][1]}, {7'd0, t.e_bd});
        chk({tag, " b_err"},   idx, {7'd0, err[d][1]},  {7'd0, t.e_be});
        chk({tag, " b_rdata"}, idx, rdata[d][1], t.e_brd);
        chk({tag, " lock_owner"}, idx, {6'd0, owner[d]}, {6'd0, t.e_lock});
        n_vec++;
    endtask

    vec_t tab0 [$];
    vec_t tab1 [$];
    vec_t tab2 [$];

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_all();
        rst_n = 1'b0;

        // Instance 0, default timeout.
        tab0.push_back(v(1, OP_WRITE,   2, 8'hA5, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_READ,    2, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'hA5, 2'b00));
        tab0.push_back(v(1, OP_HOLD,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_READ,    0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 2'b01));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_WRITE,   0, 8'hFF, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 2'b01));
        tab0.push_back(v(1, OP_READ,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab0.push_back(v(1, OP_HOLD,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab0.push_back(v(1, OP_RELEASE, 0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_READ,    1, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b00));
        tab0.push_back(v(1, OP_WRITE,   3, 8'h11, 1, OP_WRITE,   3, 8'h22, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_WRITE,   3, 8'h22, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b00));
        tab0.push_back(v(1, OP_READ,    3, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h22, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(1, OP_READ,    2, 8'h00, 1, OP_READ,    2, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'hA5, 2'b00));
        tab0.push_back(v(1, OP_READ,    2, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'hA5, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_NOP,     0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b00));
        tab0.push_back(v(1, OP_HOLD,    0, 8'h00, 1, OP_HOLD,    0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_HOLD,    0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 2'b01));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_RELEASE, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 1, 8'h00, 2'b01));
        tab0.push_back(v(1, OP_RELEASE, 0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(1, OP_RELEASE, 0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 1, 8'h00, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_WRITE,   1, 8'h5A, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b00));
        tab0.push_back(v(1, OP_READ,    1, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h5A, 0, 0, 8'h00, 2'b00));
        tab0.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00));

        // Instance 1, HOLD_TIMEOUT = 4.
        tab1.push_back(v(1, OP_WRITE,   0, 8'h77, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab1.push_back(v(1, OP_HOLD,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_WRITE,   1, 8'h33, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b00));
        tab1.push_back(v(1, OP_HOLD,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(1, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(1, OP_READ,    1, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h33, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b01));
        tab1.push_back(v(0, OP_NOP,     0, 8'h00, 0, OP_NOP,     0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab1.push_back(v(1, OP_HOLD,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b01));

        // Instance 1 after a reset in the middle of a hold.
        tab2.push_back(v(1, OP_READ,    1, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab2.push_back(v(1, OP_READ,    0, 8'h00, 0, OP_NOP,     0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 2'b00));
        tab2.push_back(v(0, OP_NOP,     0, 8'h00, 1, OP_HOLD,    0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 2'b10));

        // Reset state: grant is forced low even with a request pending.
        req[0][0] = 1'b1;
        op[0][0]  = OP_READ;
        repeat (3) @(posedge clk);
        #1;
        chk("reset a_gnt", 0, {7'd0, gnt[0][0]}, 8'h00);
        chk("reset a_done", 0, {7'd0, done[0][0]}, 8'h00);
        chk("reset b_done", 0, {7'd0, done[0][1]}, 8'h00);
        chk("reset a_rdata", 0, rdata[0][0], 8'h00);
        chk("reset lock_owner", 0, {6'd0, owner[0]}, 8'h00);
        n_vec++;
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;

        foreach (tab0[i]) run(0, tab0[i], "dut0", i);
        idle_all();
        foreach (tab1[i]) run(1, tab1[i], "dut1", i);

        // Owner read accepted, then reset before the response is consumed.
        @(negedge clk);
        req[1][0]  = 1'b1;
        op[1][0]   = OP_READ;
        addr[1][0] = 2'd1;
        @(posedge clk);
        #1;
        chk("pre-reset a_done", 0, {7'd0, done[1][0]}, 8'h01);
        chk("pre-reset a_rdata", 0, rdata[1][0], 8'h33);
        rst_n = 1'b0;
        #1;
        chk("mid-reset a_done", 0, {7'd0, done[1][0]}, 8'h00);
        chk("mid-reset a_rdata", 0, rdata[1][0], 8'h00);
        chk("mid-reset a_gnt", 0, {7'd0, gnt[1][0]}, 8'h00);
        chk("mid-reset lock_owner", 0, {6'd0, owner[1]}, 8'h00);
        n_vec++;
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;

        foreach (tab2[i]) run(1, tab2[i], "dut1 post-reset", i);
        idle_all();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
